// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: buffer enables/flushes, PC control, HLT and interrupt entry.
// Optional stall performance counter enabled by defining PIPE_STALL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW       = 3,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_hlt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              int_req,
    output logic              fd_en,
    output logic              de_en,
    output logic              em_en,
    output logic              mw_en,
    output logic              fd_flush,
    output logic              de_flush,
    output logic              pc_en,
    output logic [1:0]        pc_sel,
    output logic              int_ack,
    output logic              int_push,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [2:0] {
        S_RUN,
        S_INT_DRAIN,
        S_INT_PUSH,
        S_INT_JUMP,
        S_HALT
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic       int_ack_q, int_ack_d;
    logic       mask_q, mask_d;
    logic       load_use;

    assign load_use = ex_mem_read &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        int_ack_d = 1'b0;
        mask_d    = mask_q;
        fd_en     = 1'b1;
        de_en     = 1'b1;
        em_en     = 1'b1;
        mw_en     = 1'b1;
        fd_flush  = 1'b0;
        de_flush  = 1'b0;
        pc_en     = 1'b1;
        pc_sel    = 2'b00;
        int_push  = 1'b0;

        if (mem_busy) begin
            fd_en = 1'b0;
            de_en = 1'b0;
            em_en = 1'b0;
            mw_en = 1'b0;
            pc_en = 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (branch_taken) begin
                        pc_sel   = 2'b01;
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end else begin
                        // A sequential fetch re-opens interrupt acceptance after a handler jump.
                        mask_d = 1'b0;
                        if (int_req && !mask_q) begin
                            state_d   = S_INT_DRAIN;
                            drain_d   = DRAIN_INIT;
                            int_ack_d = 1'b1;
                        end else if (id_hlt) begin
                            state_d = S_HALT;
                        end
                    end
                end
                S_INT_DRAIN: begin
                    pc_en    = 1'b0;
                    fd_flush = 1'b1;
                    if (drain_q == 4'd0) state_d = S_INT_PUSH;
                    else                 drain_d = drain_q - 4'd1;
                end
                S_INT_PUSH: begin
                    pc_en    = 1'b0;
                    fd_flush = 1'b1;
                    int_push = 1'b1;
                    state_d  = S_INT_JUMP;
                end
                S_INT_JUMP: begin
                    pc_sel   = 2'b10;
                    fd_flush = 1'b1;
                    mask_d   = 1'b1;
                    state_d  = S_RUN;
                end
                S_HALT: begin
                    pc_en    = 1'b0;
                    fd_flush = 1'b1;
                    if (int_req) begin
                        state_d   = S_INT_DRAIN;
                        drain_d   = DRAIN_INIT;
                        int_ack_d = 1'b1;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end

        if (rst) begin
            fd_en    = 1'b1;
            de_en    = 1'b1;
            em_en    = 1'b1;
            mw_en    = 1'b1;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            pc_en    = 1'b0;
            pc_sel   = 2'b00;
            int_push = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            drain_q   <= '0;
            int_ack_q <= 1'b0;
            mask_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            int_ack_q <= int_ack_d;
            mask_q    <= mask_d;
        end
    end

    assign int_ack = int_ack_q && !rst;
    assign halted  = (state_q == S_HALT) && !rst;

`ifdef PIPE_STALL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (!pc_en && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
